// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART encodings (parity, baud) and receiver states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_e;

    typedef enum logic [1:0] {
        BAUD_2400  = 2'b00,
        BAUD_4800  = 2'b01,
        BAUD_9600  = 2'b10,
        BAUD_19200 = 2'b11
    } baud_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    function automatic int unsigned baud_hz(baud_e b);
        case (b)
            BAUD_2400:  return 2400;
            BAUD_4800:  return 4800;
            BAUD_9600:  return 9600;
            default:    return 19200;
        endcase
    endfunction

    // Rounded to nearest: CLK_FREQ / (baud * oversample)
    function automatic int unsigned baud_div(int unsigned clk_freq, baud_e b,
                                             int unsigned oversample);
        int unsigned d;
        d = baud_hz(b) * oversample;
        return (clk_freq + d / 2) / d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_baud_gen.sv
// ============================================================================
// Module      : rx_baud_gen
// Description : Oversample tick generator with restart for phase alignment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_restart,
    input  logic [1:0] i_baud_rate,
    output logic       o_tick
);

    localparam int unsigned c_DIV_2400  = baud_div(CLK_FREQ, BAUD_2400,  OVERSAMPLE);
    localparam int unsigned c_DIV_4800  = baud_div(CLK_FREQ, BAUD_4800,  OVERSAMPLE);
    localparam int unsigned c_DIV_9600  = baud_div(CLK_FREQ, BAUD_9600,  OVERSAMPLE);
    localparam int unsigned c_DIV_19200 = baud_div(CLK_FREQ, BAUD_19200, OVERSAMPLE);
    localparam int unsigned c_DIV_W     = $clog2(c_DIV_2400 + 1);

    logic [c_DIV_W-1:0] w_div_sel;
    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] r_cnt;
    logic               w_wrap;

    always_comb begin
        w_div_sel = c_DIV_W'(c_DIV_2400);
        case (baud_e'(i_baud_rate))
            BAUD_4800:  w_div_sel = c_DIV_W'(c_DIV_4800);
            BAUD_9600:  w_div_sel = c_DIV_W'(c_DIV_9600);
            BAUD_19200: w_div_sel = c_DIV_W'(c_DIV_19200);
            default:    w_div_sel = c_DIV_W'(c_DIV_2400);
        endcase
    end

    assign w_wrap = (r_cnt == r_div - c_DIV_W'(1));
    assign o_tick = w_wrap;

    // The divisor is captured only on restart so a baud change cannot
    // disturb a frame already in progress.
    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt <= '0;
            r_div <= w_div_sel;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_DIV_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rx_unit.sv
// ============================================================================
// Module      : rx_unit
// Description : UART receiver - 8 data bits, optional parity, one stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_unit
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_rx,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int unsigned             c_TICK_W = $clog2(OVERSAMPLE);
    localparam logic [c_TICK_W-1:0]     c_MID    = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0]     c_LAST   = c_TICK_W'(OVERSAMPLE - 1);

    logic [1:0]          r_sync;
    logic                w_rx_s;
    rx_state_e           r_state;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_par_bit;
    parity_e             r_par_mode;
    logic                r_armed;
    logic                w_tick;
    logic                w_restart;
    logic                w_par_en;
    logic                w_par_err;

    assign w_rx_s    = r_sync[1];
    assign w_restart = (r_state == IDLE) && !w_rx_s && r_armed;
    assign w_par_en  = (r_par_mode == PAR_ODD) || (r_par_mode == PAR_EVEN);
    // Odd wants the 9-bit XOR at 1, even wants it at 0.
    assign w_par_err = w_par_en && ((^{r_shift, r_par_bit}) != (r_par_mode == PAR_ODD));

    rx_baud_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_gen (
        .clk         (clock),
        .rst         (reset),
        .i_restart   (w_restart),
        .i_baud_rate (baud_rate),
        .o_tick      (w_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync       <= 2'b11;
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_par_mode   <= PAR_NONE;
            r_armed      <= 1'b1;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            active_flag  <= 1'b0;
            done_flag    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], data_rx};
            data_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A line left low after a bad stop bit must go high before re-arming.
                    if (w_rx_s) r_armed <= 1'b1;
                    if (w_restart) begin
                        r_state     <= START;
                        r_tick_cnt  <= '0;
                        r_par_mode  <= parity_e'(parity_type);
                        active_flag <= 1'b1;
                        done_flag   <= 1'b0;
                    end
                end
                START: if (w_tick) begin
                    if (r_tick_cnt == c_MID) begin
                        if (w_rx_s) begin
                            r_state     <= IDLE;
                            active_flag <= 1'b0;
                        end else begin
                            r_state    <= DATA;
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                    end
                end
                DATA: if (w_tick) begin
                    if (r_tick_cnt == c_LAST) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= w_par_en ? PARITY : STOP;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                    end
                end
                PARITY: if (w_tick) begin
                    if (r_tick_cnt == c_LAST) begin
                        r_tick_cnt <= '0;
                        r_par_bit  <= w_rx_s;
                        r_state    <= STOP;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                    end
                end
                STOP: if (w_tick) begin
                    if (r_tick_cnt == c_LAST) begin
                        r_tick_cnt   <= '0;
                        data_out     <= r_shift;
                        data_valid   <= 1'b1;
                        parity_error <= w_par_err;
                        frame_error  <= ~w_rx_s;
                        r_armed      <= w_rx_s;
                        r_state      <= IDLE;
                        active_flag  <= 1'b0;
                        done_flag    <= 1'b1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rx_unit.sv
// ============================================================================
// Module      : tb_rx_unit
// Description : Directed self-checking bench for rx_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_unit;

    // Scaled clock: divisors become 32/16/8/4 so frames stay short.
    localparam int unsigned CLK_FREQ  = 1_228_800;
    localparam int          BIT_2400  = 512;
    localparam int          BIT_4800  = 256;
    localparam int          BIT_9600  = 128;
    localparam int          BIT_19200 = 64;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       data_rx     = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic [1:0] baud_rate   = 2'b00;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       active_flag;
    logic       done_flag;

    int n_checks = 0;
    int n_pass   = 0;
    int base;

    logic [7:0] cap_data[$];
    logic       cap_pe[$];
    logic       cap_fe[$];

    rx_unit #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_rx      (data_rx),
        .parity_type  (parity_type),
        .baud_rate    (baud_rate),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .active_flag  (active_flag),
        .done_flag    (done_flag)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (data_valid === 1'b1) begin
            cap_data.push_back(data_out);
            cap_pe.push_back(parity_error);
            cap_fe.push_back(frame_error);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_bit(input logic v, input int n);
        data_rx = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input int bitc, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0, bitc);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bitc);
        if (par_en) drive_bit(par_bit, bitc);
        drive_bit(stop_bit, bitc);
    endtask

    task automatic check_last(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        int k;
        k = cap_data.size() - 1;
        if (k < 0) begin
            check({tag, "_present"}, 32'(cap_data.size()), 32'd1);
        end else begin
            check({tag, "_data"}, 32'(cap_data[k]), 32'(d));
            check({tag, "_perr"}, 32'(cap_pe[k]), 32'(pe));
            check({tag, "_ferr"}, 32'(cap_fe[k]), 32'(fe));
        end
    endtask

    initial begin
        repeat (4) @(negedge clock);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_valid",    32'(data_valid), 32'd0);
        check("rst_perr",     32'(parity_error), 32'd0);
        check("rst_ferr",     32'(frame_error), 32'd0);
        check("rst_active",   32'(active_flag), 32'd0);
        check("rst_done",     32'(done_flag), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // 0xA5 has four ones: even parity bit is 0
        baud_rate = 2'b10; parity_type = 2'b10;
        base = cap_data.size();
        send_frame(8'hA5, BIT_9600, 1'b1, 1'b0, 1'b1);
        check("t1_count", 32'(cap_data.size() - base), 32'd1);
        check_last("t1", 8'hA5, 1'b0, 1'b0);
        check("t1_done",   32'(done_flag), 32'd1);
        check("t1_active", 32'(active_flag), 32'd0);
        repeat (20) @(negedge clock);

        // 0x3C has four ones: odd parity needs 1, so 0 is a parity fault
        baud_rate = 2'b11; parity_type = 2'b01;
        base = cap_data.size();
        send_frame(8'h3C, BIT_19200, 1'b1, 1'b0, 1'b1);
        check("t2_count", 32'(cap_data.size() - base), 32'd1);
        check_last("t2bad", 8'h3C, 1'b1, 1'b0);
        repeat (20) @(negedge clock);
        send_frame(8'h3C, BIT_19200, 1'b1, 1'b1, 1'b1);
        check_last("t2good", 8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clock);

        // No parity (encoding 11), stop bit low, line then held low
        baud_rate = 2'b00; parity_type = 2'b11;
        base = cap_data.size();
        send_frame(8'h81, BIT_2400, 1'b0, 1'b0, 1'b0);
        check("t3_count", 32'(cap_data.size() - base), 32'd1);
        check_last("t3", 8'h81, 1'b0, 1'b1);
        repeat (3 * BIT_2400) @(negedge clock);
        check("t3_break_active", 32'(active_flag), 32'd0);
        check("t3_break_count",  32'(cap_data.size() - base), 32'd1);
        data_rx = 1'b1;
        repeat (2 * BIT_2400) @(negedge clock);
        check("t3_release_count",  32'(cap_data.size() - base), 32'd1);
        check("t3_release_active", 32'(active_flag), 32'd0);

        // 3-clock glitch: start seen, rejected at mid-bit
        baud_rate = 2'b10; parity_type = 2'b00;
        base = cap_data.size();
        data_rx = 1'b0;
        repeat (3) @(negedge clock);
        check("t4_active_rise", 32'(active_flag), 32'd1);
        data_rx = 1'b1;
        repeat (8 * 8 + 8) @(negedge clock);
        check("t4_active_fall", 32'(active_flag), 32'd0);
        check("t4_no_valid",    32'(cap_data.size() - base), 32'd0);
        repeat (BIT_9600) @(negedge clock);

        // Back-to-back frames, no idle gap
        baud_rate = 2'b01; parity_type = 2'b00;
        base = cap_data.size();
        send_frame(8'h00, BIT_4800, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, BIT_4800, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, BIT_4800, 1'b0, 1'b0, 1'b1);
        check("t5_count", 32'(cap_data.size() - base), 32'd3);
        if (cap_data.size() >= base + 3) begin
            check("t5_byte0", 32'(cap_data[base]),     32'h00);
            check("t5_byte1", 32'(cap_data[base + 1]), 32'hFF);
            check("t5_byte2", 32'(cap_data[base + 2]), 32'h55);
            check("t5_ferr0", 32'(cap_fe[base]),       32'd0);
        end
        repeat (20) @(negedge clock);

        // Abort in the middle of data bit 4, then a clean frame
        baud_rate = 2'b10; parity_type = 2'b00;
        base = cap_data.size();
        drive_bit(1'b0, BIT_9600);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h12 >> i), BIT_9600);
        drive_bit(1'b1, BIT_9600 / 2);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t6_rst_active", 32'(active_flag), 32'd0);
        check("t6_rst_data",   32'(data_out), 32'h00);
        check("t6_rst_done",   32'(done_flag), 32'd0);
        check("t6_no_pulse",   32'(cap_data.size() - base), 32'd0);
        repeat (BIT_9600) @(negedge clock);
        send_frame(8'h12, BIT_9600, 1'b0, 1'b0, 1'b1);
        check("t6_count", 32'(cap_data.size() - base), 32'd1);
        check_last("t6", 8'h12, 1'b0, 1'b0);
        check("t6_done", 32'(done_flag), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
